ntt_addr_gen: RTL and testbench
===============================

Name: ntt_addr_gen

Overview:
Sequencer directly upstream of the butterfly unit for the N=256, q=8380417 polynomial NTT/INTT. On a start pulse it walks all 8 stages × 128 butterflies. Each cycle it issues one coefficient-pair read address plus a twiddle (zeta) ROM index. It also produces the delayed write-back addresses matching the butterfly pipeline latency.

Parameters:
BF_LATENCY, 4, cycles from read issue to butterfly result valid; range 1..15; sets write-back delay.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
mode  input  2  00 NTT (Cooley-Tukey), 01 INTT (Gentleman-Sande), 1x reserved
issue_ready  input  1  memory/butterfly can accept an issue this cycle
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle pulse at completion
bf_mode  output  2  mode latched at start, drives butterfly mode
rd_en  output  1  read/issue valid
rd_addr_a  output  8  address of upper coefficient
rd_addr_b  output  8  address of lower coefficient
tw_idx  output  8  zeta ROM index; sign handling per bf_mode is done downstream
wr_en  output  1  write-back valid
wr_addr_a  output  8  write-back address for c
wr_addr_b  output  8  write-back address for d

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous and active-low. While rst_n=0, all outputs are 0, the FSM is in IDLE and the write-back pipeline is cleared. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, RUN, (BARRIER, macro only), DRAIN, DONE.
  - IDLE→RUN on start with mode[1]=0. start with mode[1]=1 is ignored.
  - RUN→DRAIN after issue 1023.
  - DRAIN→DONE when the write-back pipeline is empty.
  - DONE→IDLE after 1 cycle.
- mode is latched into bf_mode on the accepted start. bf_mode holds after done until the next accepted start. mode changes while busy are ignored.
- start while busy is ignored.
- Counters: stage s (3 bits, 0..7) and butterfly i (7 bits, 0..127). They advance only on an issue: RUN and issue_ready=1. Then rd_en=1 that cycle.
- issue_ready=0 in RUN: rd_en=0, counters hold, addresses hold their last value.
- NTT, stage s, len=128>>s, g=i>>(7-s), o=i&(len-1):
  - rd_addr_a = 2·g·len + o
  - rd_addr_b = rd_addr_a + len
  - tw_idx = (1<<s) + g
- INTT, stage s, len=1<<s, g=i>>s, o=i&(len-1):
  - addresses as above
  - tw_idx = (256>>s) − 1 − g
- rd_addr_a, rd_addr_b, tw_idx and rd_en are registered outputs. They are valid in the same cycle.
- Write-back: free-running BF_LATENCY-deep shift register of {rd_en, rd_addr_a, rd_addr_b}. wr_* equals the rd_* values from BF_LATENCY cycles earlier. It is not stalled by issue_ready.
- Timing with start at edge 0 and no stalls:
  - rd_en high cycles 1..1024
  - wr_en high cycles 1+BF_LATENCY..1024+BF_LATENCY
  - done at cycle 1025+BF_LATENCY
  - busy low in the done cycle
- Stage boundaries without the macro are back-to-back. Read-after-write forwarding is the memory subsystem's responsibility.

Optional Feature:
NTT_STAGE_BARRIER_EN
- Defined: after the last issue of stages 0..6, the FSM enters BARRIER for exactly BF_LATENCY cycles. During BARRIER, rd_en=0 and issue_ready is ignored. Stage s+1 then begins. This adds 7·BF_LATENCY cycles.
- Undefined: the BARRIER state is absent and stages are back-to-back.

Test Plan:
- NTT, BF_LATENCY=4, issue_ready=1, start at cycle 0 ->
  - issue 0: a=0, b=128, tw=1
  - issue 127: a=127, b=255, tw=1
  - stage1 issue 64: a=128, b=192, tw=3
  - last issue: a=254, b=255, tw=255
  - first wr_en at cycle 5 with wr_addr_a=0; done at cycle 1029; bf_mode=00
- INTT ->
  - issue 0: a=0, b=1, tw=255
  - issue 1: a=2, b=3, tw=254
  - stage7 issue 0: a=0, b=128, tw=1
  - last issue: a=127, b=255, tw=1
  - done at cycle 1029
- NTT with issue_ready=0 for 10 cycles at issue 300 -> rd_en=0 and addresses frozen for those cycles; no issue skipped or repeated; done at cycle 1039.
- start pulses at cycles 50 and 600, plus mode=01 at cycle 100, during an NTT -> no restart; bf_mode stays 00; single done at 1029.
- rst_n low at issue 500 -> all outputs 0 immediately; no done pulse; a new start after release begins at a=0, b=128, tw=1.
- NTT_STAGE_BARRIER_EN, BF_LATENCY=4 -> rd_en low for exactly 4 cycles between stages; done at cycle 1057.

Source files
------------

// File: rtl/ntt_addr_gen.sv
// Address and twiddle sequencer for the N=256 NTT/INTT butterfly datapath.
// Optional build macro NTT_STAGE_BARRIER_EN inserts a BF_LATENCY-cycle gap between stages.
module ntt_addr_gen #(
  parameter int BF_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       issue_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] bf_mode,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [7:0] tw_idx,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  // state   | meaning
  // IDLE    | waiting for start with a supported mode
  // RUN     | issuing butterflies, one per cycle with issue_ready
  // BARRIER | stage gap letting the butterfly pipeline empty (macro builds only)
  // DRAIN   | all issues done, waiting for write-backs to retire
  // DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
`ifdef NTT_STAGE_BARRIER_EN
    S_BARRIER,
`endif
    S_DRAIN,
    S_DONE
  } state_t;

  state_t     state;
  logic [2:0] stage;
  logic [6:0] bfly;
`ifdef NTT_STAGE_BARRIER_EN
  logic [3:0] bar_cnt;
`endif

  logic [2:0] pos;
  logic [7:0] idx8;
  logic [7:0] lo_mask;
  logic [7:0] grp;
  logic [7:0] addr_a_nxt;
  logic [7:0] addr_b_nxt;
  logic [7:0] tw_nxt;

  // The pair stride is 1<<pos; address a is the butterfly index with a zero
  // inserted at bit pos, and address b sets that bit.
  always_comb begin
    pos        = bf_mode[0] ? stage : (3'd7 - stage);
    idx8       = {1'b0, bfly};
    lo_mask    = (8'd1 << pos) - 8'd1;
    grp        = idx8 >> pos;
    addr_a_nxt = ((idx8 & ~lo_mask) << 1) | (idx8 & lo_mask);
    addr_b_nxt = addr_a_nxt | (8'd1 << pos);
    if (bf_mode[0]) tw_nxt = (8'd255 >> stage) - grp;
    else            tw_nxt = (8'd1 << stage) + grp;
  end

  logic [16:0] pipe [BF_LATENCY];
  logic        inflight;

  // Anything still to write back after the coming edge, excluding the
  // entry currently presented on wr_*.
  always_comb begin
    inflight = rd_en;
    for (int k = 0; k < BF_LATENCY - 1; k++) inflight = inflight | pipe[k][16];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      stage     <= 3'd0;
      bfly      <= 7'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bf_mode   <= 2'b00;
      rd_en     <= 1'b0;
      rd_addr_a <= 8'd0;
      rd_addr_b <= 8'd0;
      tw_idx    <= 8'd0;
`ifdef NTT_STAGE_BARRIER_EN
      bar_cnt   <= 4'd0;
`endif
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !mode[1]) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            bf_mode <= mode;
            stage   <= 3'd0;
            bfly    <= 7'd0;
          end
        end
        S_RUN: begin
          if (issue_ready) begin
            rd_en     <= 1'b1;
            rd_addr_a <= addr_a_nxt;
            rd_addr_b <= addr_b_nxt;
            tw_idx    <= tw_nxt;
            bfly      <= bfly + 7'd1;
            if (bfly == 7'd127) begin
              stage <= stage + 3'd1;
              if (stage == 3'd7) begin
                state <= S_DRAIN;
              end else begin
`ifdef NTT_STAGE_BARRIER_EN
                state   <= S_BARRIER;
                bar_cnt <= 4'(BF_LATENCY - 1);
`else
                state   <= S_RUN;
`endif
              end
            end
          end
        end
`ifdef NTT_STAGE_BARRIER_EN
        S_BARRIER: begin
          if (bar_cnt == 4'd0) state <= S_RUN;
          else                 bar_cnt <= bar_cnt - 4'd1;
        end
`endif
        S_DRAIN: begin
          if (!inflight) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running write-back delay line; never stalled by issue_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BF_LATENCY; k++) pipe[k] <= 17'd0;
    end else begin
      pipe[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int k = 1; k < BF_LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign wr_en     = pipe[BF_LATENCY-1][16];
  assign wr_addr_a = pipe[BF_LATENCY-1][15:8];
  assign wr_addr_b = pipe[BF_LATENCY-1][7:0];

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Scoreboard bench for ntt_addr_gen: spec-formula model feeds queues, a monitor checks outputs.
module tb_ntt_addr_gen;
  localparam int L = 4;
`ifdef NTT_STAGE_BARRIER_EN
  localparam int GAP = L;
`else
  localparam int GAP = 0;
`endif
  localparam int EXP_DONE = 1025 + L + 7 * GAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       issue_ready = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [1:0] bf_mode;
  logic [7:0] rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b;

  ntt_addr_gen #(.BF_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .issue_ready(issue_ready),
    .busy(busy), .done(done), .bf_mode(bf_mode), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int n_checks = 0;
  int n_fail = 0;
  int t0 = 0;
  logic [1:0]  exp_mode = 2'b00;
  logic [23:0] exp_rd[$];
  logic [15:0] exp_wr[$];
  int          rd_cyc_q[$];
  int n_issued = 0, done_seen = 0, done_cyc = 0, first_wr_cyc = -1, last_rd_cyc = 0;
  bit nostall = 1'b0;
  bit have_last = 1'b0;
  logic [23:0] last_rd = 24'd0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference: butterfly k of the 1024 in the transform, straight from the stage formulas.
  function automatic logic [23:0] model(input int m, input int k);
    int s, i, len, g, o, a, b, tw;
    s = k / 128;
    i = k % 128;
    if (m == 0) begin
      len = 128 >> s;
      g   = i >> (7 - s);
      tw  = (1 << s) + g;
    end else begin
      len = 1 << s;
      g   = i >> s;
      tw  = (256 >> s) - 1 - g;
    end
    o = i % len;
    a = 2 * g * len + o;
    b = a + len;
    return {a[7:0], b[7:0], tw[7:0]};
  endfunction

  always @(negedge clk) begin
    int rel;
    logic [23:0] e;
    logic [15:0] w;
    if (rst_n) begin
      rel = edges - t0;
      if (rd_en) begin
        if (exp_rd.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_unexpected: actual issue a=%0d required none", rd_addr_a);
        end else begin
          e = exp_rd.pop_front();
          check("rd_addr_a", rd_addr_a, e[23:16]);
          check("rd_addr_b", rd_addr_b, e[15:8]);
          check("tw_idx", tw_idx, e[7:0]);
        end
        if (nostall && n_issued > 0 && n_issued % 128 == 0)
          check("stage_gap", rel - last_rd_cyc - 1, GAP);
        n_issued++;
        last_rd_cyc = rel;
        rd_cyc_q.push_back(rel);
        have_last = 1'b1;
        last_rd = {rd_addr_a, rd_addr_b, tw_idx};
      end else if (busy && have_last) begin
        check("rd_hold", {rd_addr_a, rd_addr_b, tw_idx}, last_rd);
      end
      if (wr_en) begin
        if (exp_wr.size() == 0 || rd_cyc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wr_unexpected: actual wr a=%0d required none", wr_addr_a);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr_a", wr_addr_a, w[15:8]);
          check("wr_addr_b", wr_addr_b, w[7:0]);
          check("wr_delay", rel - rd_cyc_q.pop_front(), L);
        end
        if (first_wr_cyc < 0) first_wr_cyc = rel;
      end
      if (busy) check("bf_mode_busy", bf_mode, exp_mode);
      if (done) begin
        done_seen++;
        done_cyc = rel;
        check("busy_in_done", busy, 0);
      end
    end
  end

  task automatic load_model(input logic [1:0] m);
    logic [23:0] e;
    exp_rd.delete(); exp_wr.delete(); rd_cyc_q.delete();
    for (int k = 0; k < 1024; k++) begin
      e = model(m, k);
      exp_rd.push_back(e);
      exp_wr.push_back(e[23:8]);
    end
    exp_mode = m;
    n_issued = 0; have_last = 1'b0; first_wr_cyc = -1;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk); #1;
    start = 1'b1; mode = m; issue_ready = 1'b1;
    @(posedge clk); #1;
    t0 = edges;
    start = 1'b0;
  endtask

  // kind: 0 no stalls, 1 ten-cycle stall at issue 300, 2 random stalls, 3 start/mode disturbance
  task automatic run_op(input logic [1:0] m, input int kind, input int exp_done);
    int d0, stall_left, rel;
    bit finished;
    load_model(m);
    nostall = (kind == 0 || kind == 3);
    d0 = done_seen;
    stall_left = 10;
    finished = 1'b0;
    pulse_start(m);
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk); #1;
      rel = edges - t0;
      if (done_seen != d0) finished = 1'b1;
      case (kind)
        1: begin
          if (n_issued >= 300 && stall_left > 0) begin
            issue_ready = 1'b0; stall_left--;
          end else issue_ready = 1'b1;
        end
        2: issue_ready = ($urandom_range(0, 3) != 0);
        3: begin
          issue_ready = 1'b1;
          start = (rel == 50 || rel == 600);
          mode  = (rel >= 100 && rel < 110) ? 2'b01 : m;
        end
        default: issue_ready = 1'b1;
      endcase
    end
    start = 1'b0; issue_ready = 1'b0; mode = m;
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: actual no done required done within 3000 cycles");
    end
    if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
    else               check("done_after_last", done_cyc, last_rd_cyc + L + 1);
    check("issue_count", n_issued, 1024);
    if (nostall) check("first_wr_cycle", first_wr_cyc, 1 + L);
    repeat (4) @(negedge clk);
    #1;
    check("single_done", done_seen, d0 + 1);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("bf_mode_hold", bf_mode, m);
    check("busy_idle", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_bf_mode"}, bf_mode, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addrs"}, {rd_addr_a, rd_addr_b, tw_idx}, 0);
    check({tag, "_wr"}, {wr_en, wr_addr_a, wr_addr_b}, 0);
  endtask

  task automatic run_reset_abort();
    int d0;
    bit reached;
    load_model(2'b00);
    nostall = 1'b0;
    d0 = done_seen;
    reached = 1'b0;
    pulse_start(2'b00);
    for (int c = 0; c < 2000 && !reached; c++) begin
      @(negedge clk); #1;
      if (n_issued >= 500) reached = 1'b1;
    end
    if (!reached) begin
      n_checks++; n_fail++;
      $display("FAIL reset_reach_500: actual %0d issues required 500", n_issued);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort_done_low", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd.delete(); exp_wr.delete(); rd_cyc_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", done_seen, d0);
    check("abort_idle", busy, 0);
  endtask

  initial begin
    logic [1:0] rm;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 0, EXP_DONE);
    run_op(2'b01, 0, EXP_DONE);
    run_op(2'b00, 1, EXP_DONE + 10);
    run_op(2'b00, 3, EXP_DONE);

    // Reserved mode must not start the sequencer or disturb bf_mode.
    @(negedge clk); #1;
    start = 1'b1; mode = 2'b1 << $urandom_range(1, 1) | 2'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0; mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reserved_busy", busy, 0);
    check("reserved_bf_mode", bf_mode, exp_mode);

    run_reset_abort();
    run_op(2'b00, 0, EXP_DONE);

    for (int r = 0; r < 3; r++) begin
      rm = 2'($urandom_range(0, 1));
      run_op(rm, 2, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual time limit reached required completion");
    $fatal(1, "global timeout");
  end
endmodule
